truth_table_sampler: RTL and testbench
======================================

Name: truth_table_sampler

Overview:
- Upstream/downstream harness stage for one evolved 4-input combinational circuit-under-test (CUT), e.g. an LCELL feedback network.
- Drives every input vector onto the CUT and waits a settle time. It then samples the CUT output repeatedly and records a truth table plus a per-vector instability mask.
- Sits between the test controller (start/done) and the CUT instance; flags oscillating or metastable feedback circuits.

Parameters:
- IN_WIDTH, 4, CUT input width; NUM_VECTORS = 2**IN_WIDTH.
- SETTLE_CYCLES, 16, cycles a vector is held before sampling. Must be >= 3, because it covers the 2-cycle synchronizer.
- SAMPLES, 8, consecutive output samples per vector. Must be >= 2.

Ports:
- clk, input, 1, single system clock.
- reset, input, 1, synchronous, active-high.
- start, input, 1, one-cycle request to run a full sweep; ignored unless idle.
- cut_in, output, IN_WIDTH, vector driven to the CUT inputs (registered).
- cut_out, input, 1, raw CUT output; asynchronous, possibly oscillating.
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse when a sweep completes.
- result_valid, output, 1, high from done until the next accepted start or reset.
- truth_table, output, NUM_VECTORS, bit v = first sample taken for vector v.
- unstable_mask, output, NUM_VECTORS, bit v = 1 if any sample for vector v differed from the first.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. The synchronizer flops are cleared.
- Reset asserted mid-sweep aborts the sweep at the next edge. Partial results are discarded (cleared), and no done pulse is produced.
- cut_out passes through a 2-flop synchronizer (sync_out); all sampling uses sync_out.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - cut_in = 0, busy = 0.
  - start = 1 at an edge: truth_table and unstable_mask cleared, result_valid <= 0, vec <= 0, cut_in <= 0, busy <= 1, go to SETTLE.
- SETTLE:
  - Holds cut_in for exactly SETTLE_CYCLES cycles; cnt counts 0..SETTLE_CYCLES-1.
  - Then resets cnt and goes to SAMPLE.
- SAMPLE: exactly SAMPLES cycles.
  - Cycle 0: truth_table[vec] <= sync_out and ref <= sync_out.
  - Cycles 1..SAMPLES-1: if sync_out != ref, unstable_mask[vec] <= 1 (sticky).
  - Last cycle, vec != NUM_VECTORS-1: vec <= vec+1, cut_in <= vec+1 at the same edge, go to SETTLE.
  - Last cycle, vec == NUM_VECTORS-1: go to DONE.
  - No wrap-around of vec.
- DONE:
  - One cycle with done = 1, busy = 0, result_valid <= 1; then IDLE.
  - cut_in returns to 0 on entry to IDLE.
- Timing:
  - Per vector: SETTLE_CYCLES+SAMPLES cycles.
  - done is high in the cycle beginning NUM_VECTORS*(SETTLE_CYCLES+SAMPLES) cycles after the start-accepting edge. With defaults: 384.
- start while busy or in DONE: ignored, no queueing.
- start in the same cycle as reset: reset wins.
- truth_table and unstable_mask are stable and held while result_valid = 1.
- Widths: vec is IN_WIDTH+1 bits internally for comparison; cnt is sized for max(SETTLE_CYCLES, SAMPLES).

Decomposition:
- Package evo_test_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE).
  - function for NUM_VECTORS.
  - default constants for SETTLE_CYCLES and SAMPLES, shared by sibling harness blocks.
- Sub-module sync_2ff: 1-bit, 2-flop synchronizer with synchronous active-high reset; instantiated once for cut_out.

Test Plan:
- Behavioural CUT out = in[0] ^ in[3]; pulse start -> done after 384 cycles, truth_table = 16'h55AA, unstable_mask = 0, result_valid = 1.
- CUT out toggles every clock when in == 4'd5, else out = in[2] -> unstable_mask = 16'h0020; truth_table bits equal in[2] for all v != 5.
- Reset asserted at cycle 100 of a sweep -> next cycle busy = 0, cut_in = 0, masks 0, result_valid = 0; no done pulse. A new start then completes normally.
- start pulses at cycles 10 and 200 during a sweep -> ignored; exactly one done pulse, at the 384-cycle point.
- CUT out changes only 1 cycle after cut_in changes (SETTLE_CYCLES = 3, SAMPLES = 2) -> correct table, mask 0. The bench checks cut_in steps 0..15 in order, each held exactly 5 cycles.
- Back-to-back sweeps: start again in the cycle after done -> accepted, result_valid drops, tables cleared. The second sweep's results match the current CUT model.

Source files
------------

// File: rtl/evo_test_pkg.sv
// Shared types and defaults for the evolved-circuit test harness blocks.
// Sibling harness stages import this so they agree on sweep timing.
package evo_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_IN_WIDTH      = 4;
  localparam int DEFAULT_SETTLE_CYCLES = 16;
  localparam int DEFAULT_SAMPLES       = 8;

  function automatic int num_vectors(input int in_width);
    return 1 << in_width;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by a
// synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/truth_table_sampler.sv
// Sweeps every input vector into a combinational CUT, lets it settle, then
// samples its output repeatedly to build a truth table and instability mask.
module truth_table_sampler
  import evo_test_pkg::*;
#(
  parameter  int IN_WIDTH      = DEFAULT_IN_WIDTH,
  parameter  int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter  int SAMPLES       = DEFAULT_SAMPLES,
  localparam int NUM_VECTORS   = num_vectors(IN_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [IN_WIDTH-1:0]    cut_in,
  input  logic                   cut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   result_valid,
  output logic [NUM_VECTORS-1:0] truth_table,
  output logic [NUM_VECTORS-1:0] unstable_mask
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [IN_WIDTH:0] VEC_LAST    = (IN_WIDTH + 1)'(NUM_VECTORS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_WIDTH:0]      vec_q, vec_d;
  logic [IN_WIDTH-1:0]    cut_in_q, cut_in_d;
  logic                   sample_ref_q, sample_ref_d;
  logic [NUM_VECTORS-1:0] truth_table_q, truth_table_d;
  logic [NUM_VECTORS-1:0] unstable_mask_q, unstable_mask_d;
  logic                   result_valid_q, result_valid_d;

  logic                   sync_out;
  logic [IN_WIDTH-1:0]    vec_idx;
  logic [IN_WIDTH:0]      vec_next;

  sync_2ff u_sync_out (
    .clk   (clk),
    .reset (reset),
    .d     (cut_out),
    .q     (sync_out)
  );

  assign vec_idx  = vec_q[IN_WIDTH-1:0];
  assign vec_next = vec_q + 1'b1;

  // NOTE: every signal written below gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    vec_d           = vec_q;
    cut_in_d        = cut_in_q;
    sample_ref_d    = sample_ref_q;
    truth_table_d   = truth_table_q;
    unstable_mask_d = unstable_mask_q;
    result_valid_d  = result_valid_q;

    unique case (state_q)
      IDLE: begin
        cut_in_d = '0;
        if (start) begin
          truth_table_d   = '0;
          unstable_mask_d = '0;
          result_valid_d  = 1'b0;
          vec_d           = '0;
          cnt_d           = '0;
          state_d         = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SAMPLE: begin
        // The first sample is the reference; later ones only flag divergence.
        if (cnt_q == '0) begin
          truth_table_d[vec_idx] = sync_out;
          sample_ref_d           = sync_out;
        end else if (sync_out != sample_ref_q) begin
          unstable_mask_d[vec_idx] = 1'b1;
        end

        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          if (vec_q == VEC_LAST) begin
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            vec_d    = vec_next;
            cut_in_d = vec_next[IN_WIDTH-1:0];
            state_d  = SETTLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        cut_in_d = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the result registers are reset along with the control state so an
  // aborted sweep never leaves partial tables visible on the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      vec_q           <= '0;
      cut_in_q        <= '0;
      sample_ref_q    <= 1'b0;
      truth_table_q   <= '0;
      unstable_mask_q <= '0;
      result_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      vec_q           <= vec_d;
      cut_in_q        <= cut_in_d;
      sample_ref_q    <= sample_ref_d;
      truth_table_q   <= truth_table_d;
      unstable_mask_q <= unstable_mask_d;
      result_valid_q  <= result_valid_d;
    end
  end

  assign cut_in        = cut_in_q;
  assign busy          = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done          = (state_q == DONE);
  assign result_valid  = result_valid_q;
  assign truth_table   = truth_table_q;
  assign unstable_mask = unstable_mask_q;

endmodule

// File: tb/tb_truth_table_sampler.sv
// Directed bench: a default-timing sampler driving behavioural CUTs, plus a
// short-timing sampler whose CUT responds one cycle late.
module tb_truth_table_sampler;

  logic clk = 1'b0;
  logic reset;

  logic        start_a, cut_out_a, busy_a, done_a, rv_a;
  logic [3:0]  cut_in_a;
  logic [15:0] tt_a, um_a;

  logic        start_b, cut_out_b, busy_b, done_b, rv_b;
  logic [3:0]  cut_in_b;
  logic [15:0] tt_b, um_b;

  int checks   = 0;
  int failures = 0;
  int mode_a   = 0;

  logic       tog   = 1'b0;
  logic [3:0] dly_b = 4'd0;

  always #5 clk = ~clk;

  truth_table_sampler u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .start         (start_a),
    .cut_in        (cut_in_a),
    .cut_out       (cut_out_a),
    .busy          (busy_a),
    .done          (done_a),
    .result_valid  (rv_a),
    .truth_table   (tt_a),
    .unstable_mask (um_a)
  );

  truth_table_sampler #(
    .IN_WIDTH      (4),
    .SETTLE_CYCLES (3),
    .SAMPLES       (2)
  ) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .start         (start_b),
    .cut_in        (cut_in_b),
    .cut_out       (cut_out_b),
    .busy          (busy_b),
    .done          (done_b),
    .result_valid  (rv_b),
    .truth_table   (tt_b),
    .unstable_mask (um_b)
  );

  // CUT A: mode 0 is in[0]^in[3]; mode 1 oscillates on vector 5, else in[2].
  always @(posedge clk) tog <= ~tog;
  always_comb begin
    if (mode_a == 1)
      cut_out_a = (cut_in_a == 4'd5) ? tog : cut_in_a[2];
    else
      cut_out_a = cut_in_a[0] ^ cut_in_a[3];
  end

  // CUT B: in[1]|in[3], seen one clock after cut_in changes.
  always @(posedge clk) dly_b <= cut_in_b;
  assign cut_out_b = dly_b[1] | dly_b[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; start is seen at the next edge (offset 0).
  task automatic run_sweep_a(input string tag, input bit inject,
                             input logic [15:0] exp_tt, input logic [15:0] care,
                             input logic [15:0] exp_um);
    int done_seen;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_busy_start"}, busy_a, 1);
    check({tag, "_rv_cleared"}, rv_a, 0);
    check({tag, "_tt_cleared"}, tt_a, 0);
    check({tag, "_um_cleared"}, um_a, 0);
    check({tag, "_cut_in_start"}, cut_in_a, 0);
    done_seen = 0;
    for (int k = 1; k < 384; k++) begin
      @(negedge clk);
      if (done_a) done_seen++;
      start_a = (inject && (k == 10 || k == 200)) ? 1'b1 : 1'b0;
    end
    check({tag, "_no_early_done"}, done_seen, 0);
    @(negedge clk);
    check({tag, "_done_at_384"}, done_a, 1);
    check({tag, "_busy_in_done"}, busy_a, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done_a, 0);
    check({tag, "_rv_set"}, rv_a, 1);
    check({tag, "_truth_table"}, tt_a & care, exp_tt);
    check({tag, "_unstable"}, um_a, exp_um);
    check({tag, "_cut_in_idle"}, cut_in_a, 0);
  endtask

  initial begin
    int done_seen;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rv", rv_a, 0);
    check("rst_tt", tt_a, 0);
    check("rst_um", um_a, 0);
    check("rst_cut_in", cut_in_a, 0);
    reset = 1'b0;
    @(negedge clk);

    mode_a = 0;
    run_sweep_a("xor", 1'b0, 16'h55AA, 16'hFFFF, 16'h0000);
    repeat (5) @(negedge clk);
    check("hold_tt", tt_a, 16'h55AA);
    check("hold_rv", rv_a, 1);

    // Back-to-back: second sweep starts the cycle after its predecessor's done.
    mode_a = 1;
    run_sweep_a("osc", 1'b0, 16'hF0D0, 16'hFFDF, 16'h0020);
    mode_a = 0;
    run_sweep_a("ign", 1'b1, 16'h55AA, 16'hFFFF, 16'h0000);

    // Abort mid-sweep with reset; partial results must vanish.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (99) @(negedge clk);
    check("abort_partial_tt", tt_a, 16'h000A);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy_a, 0);
    check("abort_cut_in", cut_in_a, 0);
    check("abort_tt", tt_a, 0);
    check("abort_um", um_a, 0);
    check("abort_rv", rv_a, 0);
    start_a = 1'b1;
    @(negedge clk);
    check("reset_wins_busy", busy_a, 0);
    reset   = 1'b0;
    start_a = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_a || busy_a) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_sweep_a("rerun", 1'b0, 16'h55AA, 16'hFFFF, 16'h0000);

    // Short-timing instance: each vector held SETTLE+SAMPLES = 5 cycles.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c < 80; c++) begin
      check("b_cut_in_step", cut_in_b, c / 5);
      check("b_no_early_done", done_b, 0);
      @(negedge clk);
    end
    check("b_done_at_80", done_b, 1);
    @(negedge clk);
    check("b_rv", rv_b, 1);
    check("b_truth_table", tt_b, 16'hFFCC);
    check("b_unstable", um_b, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
